// File: rtl/nandy_pkg.sv
// Shared state encoding for the serial subtractor controller.
package nandy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_fullsubtractor.sv
// One-bit full subtractor built from gate primitives.
// diff = a ^ b ^ bin, borrow = (~a & b) | (~(a ^ b) & bin).
module Fullsubtractor (
  output logic diff,
  output logic borrow,
  input  logic inA,
  input  logic inB,
  input  logic inBorrow
);

  logic a_xor_b;
  logic a_n;
  logic xor_n;
  logic gen_b;
  logic prop_b;

  xor u_x1 (a_xor_b, inA, inB);
  xor u_x2 (diff, a_xor_b, inBorrow);
  not u_n1 (a_n, inA);
  not u_n2 (xor_n, a_xor_b);
  and u_a1 (gen_b, a_n, inB);
  and u_a2 (prop_b, xor_n, inBorrow);
  or  u_o1 (borrow, gen_b, prop_b);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A-B subtractor: IDLE -> RUN (WIDTH cycles, LSB first) -> DONE.
// Define SERIAL_SUBTRACTOR_OVERFLOW_EN to build the signed overflow flag.
//
// state | meaning
// IDLE  | waiting for inStart, operands sampled on accept
// RUN   | one bit per cycle through the full subtractor
// DONE  | one-cycle outDone, result registers just updated
module serial_subtractor
  import nandy_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inStart,
  output logic             outBusy,
  output logic             outDone,
  output logic [WIDTH-1:0] outDiff,
  output logic             outBorrow,
  output logic             outOverflow
);

  localparam int CW = $clog2(WIDTH);

  state_t state, state_nxt;

  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-2:0] res;
  logic [WIDTH-1:0] res_cat;
  logic [CW-1:0]    cnt;
  logic             borrow_ff;
  logic             bit_diff;
  logic             bit_bout;
  logic             last;

  Fullsubtractor u_fs (
    .diff     (bit_diff),
    .borrow   (bit_bout),
    .inA      (sh_a[0]),
    .inB      (sh_b[0]),
    .inBorrow (borrow_ff)
  );

  assign last    = (cnt == CW'(WIDTH - 1));
  assign res_cat = {bit_diff, res};
  assign outBusy = (state != IDLE);
  assign outDone = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (inStart) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_a      <= '0;
      sh_b      <= '0;
      res       <= '0;
      cnt       <= '0;
      borrow_ff <= 1'b0;
      outDiff   <= '0;
      outBorrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inStart) begin
            sh_a      <= inA;
            sh_b      <= inB;
            borrow_ff <= 1'b0;
            cnt       <= '0;
          end
        end
        RUN: begin
          sh_a      <= sh_a >> 1;
          sh_b      <= sh_b >> 1;
          borrow_ff <= bit_bout;
          res       <= res_cat[WIDTH-1:1];
          cnt       <= cnt + CW'(1);
          // publish on the final bit so the result is stable throughout DONE
          if (last) begin
            outDiff   <= res_cat;
            outBorrow <= bit_bout;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic sign_a;
  logic sign_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      outOverflow <= 1'b0;
    end else if (state == IDLE && inStart) begin
      sign_a <= inA[WIDTH-1];
      sign_b <= inB[WIDTH-1];
    end else if (state == RUN && last) begin
      outOverflow <= (sign_a != sign_b) && (bit_diff != sign_a);
    end
  end
`else
  assign outOverflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8: vector table,
// random operands against an arithmetic model, and multi-cycle corner cases.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic         inStart;
  logic         outBusy;
  logic         outDone;
  logic [W-1:0] outDiff;
  logic         outBorrow;
  logic         outOverflow;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .inA         (inA),
    .inB         (inB),
    .inStart     (inStart),
    .outBusy     (outBusy),
    .outDone     (outDone),
    .outDiff     (outDiff),
    .outBorrow   (outBorrow),
    .outOverflow (outOverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (outDone) done_cnt++;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf_when_en;
  } vec_t;

  vec_t vecs[7];

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arithmetic reference: unsigned difference, borrow, signed-range overflow.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] d, output logic bo, output logic ov);
    int sd;
    d  = W'((a - b) & ((1 << W) - 1));
    bo = (int'(a) < int'(b));
    sd = int'($signed(a)) - int'($signed(b));
    ov = OVF_EN && ((sd > 127) || (sd < -128));
  endtask

  // Starts an operation and waits for outDone; caller is 1 time unit past a posedge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input string tag);
    int lat;
    int held_bad;
    logic [W-1:0] prev_d;
    prev_d   = outDiff;
    held_bad = 0;
    inA = a;
    inB = b;
    inStart = 1'b1;
    tick();
    inStart = 1'b0;
    lat = 1;
    while (!outDone && lat < 40) begin
      if (outDiff !== prev_d || !outBusy) held_bad++;
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 9);
    chk({tag, "_run_hold_busy"}, held_bad, 0);
    chk({tag, "_diff"}, outDiff, ed);
    chk({tag, "_borrow"}, outBorrow, eb);
    chk({tag, "_ovf"}, outOverflow, eo);
    chk({tag, "_busy_done"}, outBusy, 1);
    tick();
    chk({tag, "_idle_after"}, {outBusy, outDone}, 2'b00);
    chk({tag, "_diff_held"}, outDiff, ed);
  endtask

  initial begin
    logic [W-1:0] ra, rb, md;
    logic mb, mo;
    int d0, t_last, n_done, gap_bad;

    vecs[0] = '{8'h5A, 8'h13, 8'h47, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h01, 8'h80, 8'h81, 1'b1, 1'b1};
    vecs[5] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
    vecs[6] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};

    reset = 1'b1;
    inStart = 1'b0;
    inA = '0;
    inB = '0;
    tick();
    tick();
    chk("reset_outputs", {outBusy, outDone, outDiff, outBorrow, outOverflow}, '0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow,
             OVF_EN && vecs[i].ovf_when_en, $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      model(ra, rb, md, mb, mo);
      run_op(ra, rb, md, mb, mo, $sformatf("rnd%0d", i));
    end

    // start pulsed mid-RUN with new operands must be ignored
    d0 = done_cnt;
    inA = 8'h33;
    inB = 8'h11;
    inStart = 1'b1;
    tick();
    inStart = 1'b0;
    tick();
    tick();
    tick();
    inA = 8'hAA;
    inB = 8'h55;
    inStart = 1'b1;
    tick();
    inStart = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    chk("midrun_done_count", done_cnt - d0, 1);
    chk("midrun_diff", outDiff, 8'h22);
    chk("midrun_busy", outBusy, 0);

    // reset in RUN cycle 4 discards the operation
    inA = 8'h5A;
    inB = 8'h13;
    inStart = 1'b1;
    tick();
    inStart = 1'b0;
    tick();
    tick();
    tick();
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    chk("midreset_outputs", {outBusy, outDone, outDiff, outBorrow, outOverflow}, '0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("midreset_no_done", done_cnt - d0, 0);
    chk("midreset_idle", {outBusy, outDiff}, '0);
    run_op(8'h5A, 8'h13, 8'h47, 1'b0, 1'b0, "after_reset");

    // start held high: back-to-back operations, outDone every 10 cycles
    inA = 8'h00;
    inB = 8'h01;
    inStart = 1'b1;
    t_last = -1;
    n_done = 0;
    gap_bad = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (outDone) begin
        if (t_last >= 0 && (c - t_last) != 10) gap_bad++;
        if (outDiff !== 8'hFF || outBorrow !== 1'b1) gap_bad++;
        t_last = c;
        n_done++;
      end
    end
    inStart = 1'b0;
    chk("held_start_done_count", n_done, 3);
    chk("held_start_spacing", gap_bad, 0);
    for (int i = 0; i < 40 && outBusy; i++) tick();
    chk("held_start_idle", outBusy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
